reg_transfer_ctrl: RTL and testbench
====================================

Name: reg_transfer_ctrl

Overview:
- Parametrised bus-transfer controller for a register file of N registers sharing one tri-state bus, plus one dedicated temporary register T.
- On a start request it sequences the register in/out enables to perform one of two operations:
  - MOVE: R[dst] <= R[src].
  - SWAP: exchange R[src] and R[dst] through T.
- Operands are latched at start; the block signals completion, busy and illegal-request status.
- Sits between the datapath register file/bus and the upstream sequencer that issues transfer requests.

Parameters:
- N, default 3: number of bus registers; legal range 2..2^SELW.
- SELW, default 2: width of the src/dst register index.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- w  input  1  start request; sampled only in IDLE.
- mode  input  1  0 = MOVE, 1 = SWAP; latched with w.
- src  input  SELW  source register index; latched with w.
- dst  input  SELW  destination register index; latched with w.
- Rin  output  N  one-hot load enables for R[0..N-1].
- Rout  output  N  one-hot bus-drive enables for R[0..N-1].
- Tin  output  1  load enable for T.
- Tout  output  1  bus-drive enable for T.
- Done  output  1  high during the final cycle of every accepted request.
- Busy  output  1  high in every state except IDLE.
- Err  output  1  high with Done when the request was illegal.

Behaviour:
- Reset: Clock is the only clock; Resetn is asynchronous and active-low.
  - Resetn=0 forces state to IDLE immediately, not waiting for Clock.
  - Latched mode/src/dst are cleared to 0.
  - All outputs are 0 while in IDLE, so they deassert asynchronously on reset.
- Outputs are Moore: a combinational decode of state plus the latched operands only.
  - No output depends on the live w/mode/src/dst inputs.
- States: IDLE, S1, S2, S3, MV, NOP, ERR.
- IDLE: if w=1 at the rising edge, latch mode/src/dst and select the next state by priority:
  - src>=N or dst>=N -> ERR.
  - else src==dst -> NOP.
  - else mode=0 -> MV.
  - else -> S1.
  - If w=0, stay in IDLE.
- MV: Rout[src]=1, Rin[dst]=1, Done=1. Next state IDLE.
- S1: Rout[src]=1, Tin=1. Next state S2.
- S2: Rout[dst]=1, Rin[src]=1. Next state S3.
- S3: Tout=1, Rin[dst]=1, Done=1. Next state IDLE.
- NOP: no enables asserted, Done=1. Next state IDLE.
- ERR: no enables asserted, Done=1, Err=1. Next state IDLE.
- Latency, counted from the edge that samples w=1:
  - MOVE: Done in the 1st following cycle.
  - SWAP: Done in the 3rd following cycle.
  - NOP/ERR: Done in the 1st following cycle.
- Bus-safety invariant: in every cycle, at most one bit of {Rout, Tout} is 1 and at most one bit of {Rin, Tin} is 1.
- Busy is 1 in S1, S2, S3, MV, NOP and ERR.
- w is ignored whenever state is not IDLE; operand inputs may change freely during Busy without effect.
- Back-to-back requests: the state always returns to IDLE for at least one cycle after Done.
  - The next w is sampled at the edge that ends that IDLE cycle.
  - Minimum request period: 2 cycles for MOVE, 4 cycles for SWAP.
- Reset during S1/S2: the partial transfer is abandoned; Done is not asserted.
  - T and register contents are not the controller's concern.

Test Plan:
- Default N=3, SWAP src=1, dst=0:
  - Following cycles show (Rout[1], Tin), then (Rout[0], Rin[1]), then (Tout, Rin[0], Done).
  - Busy is high for exactly 3 cycles, then IDLE.
- MOVE src=2, dst=1: Rout=3'b100, Rin=3'b010, Done=1 for exactly 1 cycle; Err=0; no Tin/Tout.
- SWAP src=dst=2: one cycle with Done=1, Busy=1, all enables 0, Err=0.
- N=3, src=3 (out of range), either mode: one cycle with Done=1, Err=1, all enables 0.
- Start during an operation: hold w=1 with changing src/dst through a SWAP.
  - The SWAP completes with its original operands.
  - The next request is accepted at the edge that ends the IDLE cycle after Done.
- Async reset: assert Resetn=0 mid-cycle during S2.
  - All outputs drop to 0 without waiting for a Clock edge.
  - After release, w=0 keeps the block in IDLE.
- Throughout all scenarios, an assertion checks the one-hot bus-safety invariant on every cycle.

Source files
------------

// File: rtl/reg_transfer_ctrl.sv
// reg_transfer_ctrl: sequences register-file bus enables for MOVE and SWAP transfers
module reg_transfer_ctrl #(
    parameter int N    = 3,
    parameter int SELW = 2
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            w,
    input  logic            mode,
    input  logic [SELW-1:0] src,
    input  logic [SELW-1:0] dst,
    output logic [N-1:0]    Rin,
    output logic [N-1:0]    Rout,
    output logic            Tin,
    output logic            Tout,
    output logic            Done,
    output logic            Busy,
    output logic            Err
);
    typedef enum logic [2:0] {IDLE, S1, S2, S3, MV, NOP, ERR} state_t;
    localparam logic [N-1:0] ONE = 1;
    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [SELW-1:0] src_q, src_d, dst_q, dst_d;
    logic [N-1:0]    src_oh, dst_oh;
    assign src_oh = ONE << src_q;
    assign dst_oh = ONE << dst_q;
    // state and operand registers, cleared asynchronously
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
        end
    end
    // request acceptance in IDLE with range/alias/mode priority, then fixed sequencing
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        case (state_q)
            IDLE: if (w) begin
                mode_d  = mode;
                src_d   = src;
                dst_d   = dst;
                state_d = (32'(src) >= N || 32'(dst) >= N) ? ERR :
                          (src == dst) ? NOP : mode ? S1 : MV;
            end
            S1:      state_d = S2;
            S2:      state_d = S3;
            default: state_d = IDLE;
        endcase
    end
    // Moore output decode; swap phases are qualified by the latched mode
    always_comb begin
        Busy = state_q != IDLE;
        Done = state_q inside {MV, S3, NOP, ERR};
        Err  = state_q == ERR;
        Tin  = state_q == S1 && mode_q;
        Tout = state_q == S3 && mode_q;
        Rout = (state_q == MV || Tin) ? src_oh : (state_q == S2 && mode_q) ? dst_oh : '0;
        Rin  = (state_q == MV || Tout) ? dst_oh : (state_q == S2 && mode_q) ? src_oh : '0;
    end
endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// tb_reg_transfer_ctrl: randomized and directed checks of reg_transfer_ctrl against a sequence model
module tb_reg_transfer_ctrl;
    localparam int N    = 3;
    localparam int SELW = 2;
    logic            Clock = 0;
    logic            Resetn = 0;
    logic            w = 0;
    logic            mode = 0;
    logic [SELW-1:0] src = 0;
    logic [SELW-1:0] dst = 0;
    logic [N-1:0]    Rin, Rout;
    logic            Tin, Tout, Done, Busy, Err;
    logic [2*N+4:0]  obs;
    int              tests = 0;
    int              fails = 0;

    reg_transfer_ctrl #(.N(N), .SELW(SELW)) dut (
        .Clock(Clock), .Resetn(Resetn), .w(w), .mode(mode), .src(src), .dst(dst),
        .Rin(Rin), .Rout(Rout), .Tin(Tin), .Tout(Tout), .Done(Done), .Busy(Busy), .Err(Err)
    );

    always #5 Clock = ~Clock;
    assign obs = {Rin, Rout, Tin, Tout, Done, Busy, Err};

    // bus-safety invariant on every cycle
    always @(negedge Clock) begin
        tests++;
        assert ($countones({Rout, Tout}) <= 1 && $countones({Rin, Tin}) <= 1)
        else begin
            fails++;
            $display("FAIL bus_safety: drive=%b load=%b required at most one bit each", {Rout, Tout}, {Rin, Tin});
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

    function automatic int nsteps(input logic m, input int s, input int d);
        return (s < N && d < N && s != d && m) ? 3 : 1;
    endfunction

    // expected {Rin,Rout,Tin,Tout,Done,Busy,Err} for one cycle of a request
    function automatic logic [2*N+4:0] exp_vec(input logic m, input int s, input int d, input int step);
        logic [N-1:0] ri, ro;
        logic ti, to, dn, er;
        ri = '0; ro = '0; ti = 0; to = 0; dn = 0; er = 0;
        if (s >= N || d >= N) begin dn = 1; er = 1; end
        else if (s == d) dn = 1;
        else if (!m) begin ro[s] = 1; ri[d] = 1; dn = 1; end
        else if (step == 0) begin ro[s] = 1; ti = 1; end
        else if (step == 1) begin ro[d] = 1; ri[s] = 1; end
        else begin to = 1; ri[d] = 1; dn = 1; end
        return {ri, ro, ti, to, dn, 1'b1, er};
    endfunction

    // issue one request at a negedge; returns at the negedge of the IDLE cycle after Done
    task automatic run_req(input logic m, input int s, input int d, input bit noisy, input string nm);
        logic [2*N+4:0] e;
        w = 1; mode = m; src = s[SELW-1:0]; dst = d[SELW-1:0];
        @(posedge Clock); #1;
        if (noisy) begin mode = 1'($urandom); src = SELW'($urandom); dst = SELW'($urandom); end
        else w = 0;
        for (int k = 0; k < nsteps(m, s, d); k++) begin
            @(negedge Clock);
            e = exp_vec(m, s, d, k);
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL %s step %0d: got %b required %b", nm, k, obs, e);
            end
            if (noisy) begin mode = 1'($urandom); src = SELW'($urandom); dst = SELW'($urandom); end
        end
        @(negedge Clock);
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL %s idle_after_done: got %b required 0", nm, obs);
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (obs !== '0) begin fails++; $display("FAIL reset_state: got %b required 0", obs); end
        repeat (2) @(negedge Clock);
        Resetn = 1;
        @(negedge Clock);
        tests++;
        if (obs !== '0) begin fails++; $display("FAIL idle_after_reset: got %b required 0", obs); end
    endtask

    task automatic test_directed();
        run_req(1, 1, 0, 0, "swap_1_0");
        run_req(0, 2, 1, 0, "move_2_1");
        run_req(1, 2, 2, 0, "swap_alias");
        run_req(0, 3, 1, 0, "err_move_src3");
        run_req(1, 3, 0, 0, "err_swap_src3");
        run_req(0, 0, 3, 0, "err_dst3");
    endtask

    task automatic test_w_held();
        run_req(1, 0, 2, 1, "held_swap");
        run_req(0, 1, 2, 1, "held_next_move");
        run_req(1, 2, 1, 1, "held_next_swap");
        w = 0;
    endtask

    task automatic test_async_reset();
        w = 1; mode = 1; src = 2; dst = 0;
        @(posedge Clock); #1 w = 0;
        @(posedge Clock); #2;
        tests++;
        if (obs !== exp_vec(1, 2, 0, 1)) begin fails++; $display("FAIL pre_reset_s2: got %b required %b", obs, exp_vec(1, 2, 0, 1)); end
        Resetn = 0;
        #1;
        tests++;
        if (obs !== '0) begin fails++; $display("FAIL async_reset_drop: got %b required 0", obs); end
        @(negedge Clock);
        Resetn = 1;
        repeat (3) begin
            @(negedge Clock);
            tests++;
            if (obs !== '0) begin fails++; $display("FAIL post_reset_idle: got %b required 0", obs); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_req(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom), "random");
            w = 0;
            repeat ($urandom_range(0, 2)) begin
                @(negedge Clock);
                tests++;
                if (obs !== '0) begin fails++; $display("FAIL random_gap_idle: got %b required 0", obs); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_w_held();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
